// File: rtl/mux_rr_stream.sv
// mux_rr_stream
//   Merges NUM_CH valid/ready input streams into one registered output stream.
//   Either an explicit selector or fair round-robin chooses the source channel.
//   The output register gives one cycle of latency and sustains one word per
//   cycle under back-pressure.
//
// Handshake: a word moves across an interface on a rising clk_i edge where
//   both valid and ready are high. Ready never depends on anything registered
//   on the other side of this block's output. Valid may be dropped before
//   ready arrives; nothing transfers in that case.
//
// Ports
//   clk_i           rising-edge clock
//   rst_i           synchronous active-high reset
//   mode_i          0 = explicit select, 1 = round-robin
//   selector_i      channel index used in select mode
//   channel_data_i  packed input data, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   channel_valid_i per-channel valid
//   channel_ready_o per-channel ready, at most one bit high
//   channel_out_o   registered output data
//   out_valid_o     output valid
//   out_ready_i     downstream ready
//   grant_o         index of the channel whose word is in the output register
module mux_rr_stream #(
  parameter int NUM_CH     = 8,
  parameter int DATA_WIDTH = 32,
  localparam int SEL_W     = $clog2(NUM_CH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         mode_i,
  input  logic [SEL_W-1:0]             selector_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] channel_data_i,
  input  logic [NUM_CH-1:0]            channel_valid_i,
  output logic [NUM_CH-1:0]            channel_ready_o,
  output logic [DATA_WIDTH-1:0]        channel_out_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [SEL_W-1:0]             grant_o
);

  logic [SEL_W-1:0]      last_grant;
  logic                  accept;
  logic                  req;
  logic [SEL_W-1:0]      chosen;
  logic [DATA_WIDTH-1:0] chosen_data;
  logic                  take;

  logic                  sel_req;
  logic                  rr_found;
  logic [SEL_W-1:0]      rr_idx;
  logic [2*NUM_CH-1:0]   valid2;

  // Output register is empty or is being drained this cycle.
  assign accept = !out_valid_o || out_ready_i;

  // Select mode: an out-of-range selector matches no channel, so req stays 0.
  always_comb begin
    sel_req = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (selector_i == SEL_W'(k)) sel_req = channel_valid_i[k];
    end
  end

  // Round-robin: scan a doubled copy of the valid vector starting one past
  // last_grant; the first hit modulo NUM_CH is the winner.
  assign valid2 = {channel_valid_i, channel_valid_i};

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = 0; i < 2 * NUM_CH; i++) begin
      if (!rr_found && (i > int'(last_grant)) && valid2[i]) begin
        rr_found = 1'b1;
        rr_idx   = (i >= NUM_CH) ? SEL_W'(i - NUM_CH) : SEL_W'(i);
      end
    end
  end

  always_comb begin
    if (mode_i) begin
      chosen = rr_idx;
      req    = rr_found;
    end else begin
      chosen = selector_i;
      req    = sel_req;
    end
  end

  always_comb begin
    channel_ready_o = '0;
    chosen_data     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (chosen == SEL_W'(k)) begin
        channel_ready_o[k] = accept && req && !rst_i;
        chosen_data        = channel_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign take = |(channel_ready_o & channel_valid_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o   <= 1'b0;
      channel_out_o <= '0;
      grant_o       <= '0;
      last_grant    <= SEL_W'(NUM_CH - 1);
    end else if (take) begin
      out_valid_o   <= 1'b1;
      channel_out_o <= chosen_data;
      grant_o       <= chosen;
      last_grant    <= chosen;
    end else if (out_valid_o && out_ready_i) begin
      // Drained with nothing new: data and grant keep their last value.
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_stream.sv
// tb_mux_rr_stream
//   Directed test-plan steps followed by a randomized phase, all compared
//   against a transaction-level reference model of the merge stream.
module tb_mux_rr_stream;

  localparam int NUM_CH = 8;
  localparam int DW     = 32;
  localparam int SW     = $clog2(NUM_CH);

  logic                 clk;
  logic                 rst;
  logic                 mode;
  logic [SW-1:0]        sel;
  logic [NUM_CH*DW-1:0] data_bus;
  logic [NUM_CH-1:0]    valid;
  logic [NUM_CH-1:0]    ready;
  logic [DW-1:0]        out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SW-1:0]        grant;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_grant;
  int            m_last;

  mux_rr_stream #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .mode_i          (mode),
    .selector_i      (sel),
    .channel_data_i  (data_bus),
    .channel_valid_i (valid),
    .channel_ready_o (ready),
    .channel_out_o   (out_data),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .grant_o         (grant)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [DW-1:0] v);
    data_bus[k*DW +: DW] = v;
  endtask

  function automatic logic [DW-1:0] ch_data(input int k);
    return data_bus[k*DW +: DW];
  endfunction

  // Which channel the block should take this cycle, -1 for none.
  function automatic int model_pick();
    int k;
    if (rst) return -1;
    if (m_valid && !out_ready) return -1;
    if (!mode) begin
      if (int'(sel) < NUM_CH && valid[sel]) return int'(sel);
      return -1;
    end
    for (int d = 1; d <= NUM_CH; d++) begin
      k = (m_last + d) % NUM_CH;
      if (valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_grant = 0;
    m_last  = NUM_CH - 1;
  endtask

  // One clock: check combinational ready and registered outputs mid-cycle,
  // then advance the model across the rising edge.
  task automatic tick();
    int p;
    logic [NUM_CH-1:0] exp_ready;
    @(negedge clk);
    p = model_pick();
    exp_ready = '0;
    if (p >= 0) exp_ready[p] = 1'b1;
    check("ready", 64'(ready), 64'(exp_ready));
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_data", 64'(out_data), 64'(m_data));
    check("grant", 64'(grant), 64'(m_grant));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (p >= 0) begin
      m_valid = 1'b1;
      m_data  = ch_data(p);
      m_grant = p;
      m_last  = p;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  initial begin
    int exp_seq[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    rst = 1'b1; mode = 1'b0; sel = '0; valid = '0; out_ready = 1'b0;
    data_bus = '0;
    @(posedge clk); #1;
    model_reset();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    rst = 1'b0;

    // Round-robin across all channels, full throughput.
    mode = 1'b1; out_ready = 1'b1; valid = '1;
    for (int k = 0; k < NUM_CH; k++) set_ch(k, 32'h1000_0000 + DW'(k));
    for (int i = 0; i < 9; i++) begin
      tick();
      check("rr_all_grant", 64'(grant), 64'(exp_seq[i]));
      check("rr_all_data", 64'(out_data), 64'(32'h1000_0000 + exp_seq[i]));
      check("rr_all_valid", 64'(out_valid), 64'd1);
    end

    // Only channels 2 and 6 requesting.
    valid = 8'b0100_0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_26_grant", 64'(grant), (i % 2 == 0) ? 64'd2 : 64'd6);
    end

    // Select mode with a stalled consumer.
    mode = 1'b0; sel = 3'd5; valid = 8'b0010_0000; set_ch(5, 32'hDEAD_BEEF);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_data", 64'(out_data), 64'hDEAD_BEEF);
      check("stall_ready", 64'(ready), 64'd0);
    end
    set_ch(5, 32'hCAFE_0005);
    out_ready = 1'b1;
    tick();
    check("resume_data", 64'(out_data), 64'hCAFE_0005);

    // Selected channel idle while others request: output drains.
    sel = 3'd3; valid = 8'b1111_0111;
    tick();
    tick();
    check("drain_valid", 64'(out_valid), 64'd0);

    // Grant in select mode carries over into round-robin.
    sel = 3'd4; valid = '1;
    tick();
    check("sel4_grant", 64'(grant), 64'd4);
    mode = 1'b1;
    tick();
    check("switch_grant", 64'(grant), 64'd5);

    // Reset while a word is held.
    out_ready = 1'b0; valid = 8'b0000_0010;
    tick();
    rst = 1'b1;
    tick();
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_data", 64'(out_data), 64'd0);
    check("midrst_grant", 64'(grant), 64'd0);
    rst = 1'b0; out_ready = 1'b1; valid = 8'b0000_0011;
    tick();
    check("post_rst_grant", 64'(grant), 64'd0);

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      mode      = 1'($urandom_range(0, 1));
      sel       = SW'($urandom_range(0, NUM_CH - 1));
      valid     = NUM_CH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NUM_CH; k++) set_ch(k, $urandom);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_rr_stream.md
Name: mux_rr_stream

Overview:
- Parametrised successor to the team's fixed 8x32b clocked mux.
- Merges NUM_CH valid/ready input streams of DATA_WIDTH bits into one registered output stream.
- Two arbitration modes: explicit select, or fair round-robin across requesting channels.
- Sits between multiple producers and a single downstream consumer. Gives one-cycle latency with full throughput under back-pressure.

Parameters:
- NUM_CH, 8, number of input channels (2..32).
- DATA_WIDTH, 32, data bits per channel.
- SEL_W, $clog2(NUM_CH), width of selector and grant index (derived, not overridden).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous reset, active-high.
- mode_i  input  1  0 = explicit select, 1 = round-robin.
- selector_i  input  SEL_W  channel index used in select mode.
- channel_data_i  input  NUM_CH*DATA_WIDTH  packed data; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- channel_valid_i  input  NUM_CH  per-channel valid.
- channel_ready_o  output  NUM_CH  per-channel ready; at most one bit high per cycle.
- channel_out_o  output  DATA_WIDTH  registered output data.
- out_valid_o  output  1  output valid.
- out_ready_i  input  1  downstream ready.
- grant_o  output  SEL_W  index of the channel whose data is in the output register.

Behaviour:
- Reset (sampled at clk_i edge with rst_i=1):
  - out_valid_o=0, channel_out_o=0, grant_o=0.
  - RR pointer last_grant=NUM_CH-1, so channel 0 has highest priority first.
  - While rst_i=1, channel_ready_o is all zeros.
- Reset mid-operation: any word held in the output register is discarded; no input transfer occurs on a reset cycle.
- accept = !out_valid_o || out_ready_i (combinational; output register free or draining this cycle).
- Choice, select mode:
  - chosen = selector_i.
  - req = channel_valid_i[selector_i].
  - selector_i >= NUM_CH (non-power-of-2 NUM_CH) gives req=0; no channel is ready.
- Choice, RR mode:
  - chosen = first k with channel_valid_i[k]=1, scanning last_grant+1, last_grant+2, ... modulo NUM_CH.
  - req = |channel_valid_i.
- Ready: channel_ready_o[k] = accept && req && (k==chosen) && !rst_i. Combinational from channel_valid_i, mode_i, selector_i and out_ready_i; no other ready bit is high.
- Input transfer on channel k = channel_valid_i[k] && channel_ready_o[k] at the clock edge. At that edge:
  - channel_out_o <= channel k data.
  - grant_o <= k.
  - out_valid_o <= 1.
  - last_grant <= k (both modes).
- Output transfer = out_valid_o && out_ready_i. If there is no simultaneous input transfer, out_valid_o <= 0; channel_out_o and grant_o hold their last value.
- Simultaneous output and input transfer: out_valid_o stays 1 and the new word loads, giving one word per cycle sustained.
- Stall (out_valid_o=1, out_ready_i=0):
  - channel_out_o, grant_o and out_valid_o are held stable.
  - All channel_ready_o=0.
  - Changes to selector_i or mode_i take effect at the next accept.
- Latency: input transfer at edge N gives out_valid_o=1 with that data from edge N.
- Mode switch: last_grant is retained across switches. RR resumes after the last granted channel, including grants made in select mode.
- Wrap-around: with last_grant=NUM_CH-1, the scan begins at channel 0.
- Upstream drops valid before ready: no transfer and no pointer update.

Test Plan:
- Reset, then RR mode with all 8 channels valid (ch k data = 0x1000_0000+k), out_ready_i=1 -> grant_o sequence 0,1,...,7,0; one word per cycle; channel_out_o 0x10000000..0x10000007.
- RR mode, only ch2 and ch6 valid, out_ready_i=1 -> grants alternate 2,6,2,6; ready never asserted on other channels.
- Select mode, selector_i=5, ch5 valid with 0xDEADBEEF, out_ready_i=0 for 3 cycles -> out_valid_o=1, data held 0xDEADBEEF, all channel_ready_o=0. Raise out_ready_i -> next ch5 word loads in the same cycle.
- Select mode, selector_i=3, ch3 invalid, others valid -> channel_ready_o all 0; out_valid_o falls to 0 after draining.
- Mode switch: select grants ch4, then mode_i=1 with all channels valid -> next grant is ch5.
- Assert rst_i while out_valid_o=1 and ch1 valid -> next cycle out_valid_o=0, channel_out_o=0, grant_o=0. After release, first RR grant is ch0 if ch0 is valid.
